conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
- Parametrised successor to the fixed 32-bit 3x3 convolution block.
- Streams a raster-order single-channel image (IMG_W x IMG_H) and emits valid-region (no padding) 3x3 convolution results.
- Signed fixed-point data with runtime-loadable kernel plus bias, selectable stride 1/2, and a registered MAC pipeline with shift and saturation.
- Sits between the pixel source and the next layer (pool/flatten) in the CNN datapath.

Parameters:
- DATA_W, 16, signed pixel and output width
- COEF_W, 16, signed kernel/bias word width
- IMG_W, 28, image width in pixels (>=3)
- IMG_H, 28, image height in rows (>=3)
- ACC_W, DATA_W+COEF_W+4, accumulator width
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- kernel_valid  in  1  kernel word strobe
- kernel_in  in  COEF_W  kernel word: k1..k9 row-major, then bias (10 words)
- load_kernel_done  out  1  high once all 10 words are loaded
- valid_in  in  1  pixel strobe
- data_in  in  DATA_W  signed pixel
- in_ready  out  1  pixel accepted when valid_in & in_ready
- stride2  in  1  0 = stride 1, 1 = stride 2; sampled on acceptance of pixel (0,0)
- valid_out  out  1  data_out valid
- data_out  out  DATA_W  signed result
- frame_done  out  1  one-cycle pulse coincident with the last valid_out of a frame

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset:
  - load_kernel_done=0, in_ready=0, valid_out=0, data_out=0, frame_done=0.
  - Coefficients and bias cleared to 0; col/row counters cleared to 0; all pipeline valids cleared.
  - Reset mid-frame or mid-load discards everything in flight.
- FSM LOAD → RUN:
  - After reset the FSM is in LOAD.
  - Each kernel_valid cycle writes word index 0..9. The 10th word sets load_kernel_done=1 and moves to RUN.
- Kernel reload:
  - In RUN, kernel_valid is honoured only when the frame position is (0,0), i.e. no partial frame is buffered.
  - An honoured reload clears load_kernel_done, restarts at word 0 and returns to LOAD.
  - kernel_valid elsewhere in RUN is ignored.
- in_ready = load_kernel_done & ~(kernel_valid & at_origin).
  - A simultaneous kernel word and pixel at origin: the kernel word wins and the pixel is not accepted.
- Position counters:
  - col advances on each accepted pixel and wraps at IMG_W-1, incrementing row.
  - row wraps at IMG_H-1 to 0 (frame end).
  - Idle cycles (valid_in=0) hold the counters.
- Line buffer: two IMG_W-deep rows plus 3x3 window registers, updated only on accepted pixels.
- Output selection:
  - A window is produced when row>=2 and col>=2, giving (IMG_W-2) x (IMG_H-2) outputs at stride 1.
  - With stride2=1, additionally (row-2) and (col-2) must both be even.
- Pipeline: advances every cycle regardless of valid_in; valid bits travel with the data.
  - S1: nine products, each DATA_W+COEF_W bits.
  - S2: sign-extended sum of the products plus sign-extended bias, in ACC_W bits.
  - S3: arithmetic >> OUT_SHIFT, saturate to signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1], optional ReLU.
- Latency: valid_out rises exactly 3 clock edges after the edge that accepted the window-completing pixel.
- No backpressure on the output side.
- frame_done pulses with the valid_out of window (IMG_H-1, IMG_W-1).
  - That window is always the final output in stride-1 mode.
  - In stride-2 mode frame_done pulses on the last emitted window.

Optional Feature:
- Macro CONV2D_RELU_EN.
- Defined: after saturation, negative results are forced to 0.
- Undefined: signed saturated result is passed through unchanged.

Decomposition:
- Package conv2d_pkg holds:
  - KSIZE=3, NUM_TAPS=9, LOAD_WORDS=10
  - FSM state enum {LOAD, RUN}
  - saturate/shift helper function
- One natural sub-module, conv_linebuf: line buffers plus 3x3 window, counters, window-valid/stride logic.

Test Plan:
All scenarios use IMG_W=IMG_H=5, DATA_W=COEF_W=16, OUT_SHIFT=0.
1. Basic stride 1:
   - Stimulus: kernel all 1, bias 0, pixels 1..25 back-to-back, stride2=0.
   - Response: 9 outputs 63,72,81,108,117,126,153,162,171; first valid_out 3 edges after pixel 13 accepted; frame_done with 171.
2. Stride 2:
   - Stimulus: same as 1 with stride2=1.
   - Response: outputs 63,81,153,171 only; frame_done with 171.
3. Gapped input:
   - Stimulus: same as 1 with valid_in asserted every other cycle.
   - Response: identical values and order; no valid_out during input gaps beyond pipeline drain.
4. Sign, saturation and ReLU:
   - Stimulus A: kernel all -1, pixels 1000.
   - Response A: -9000 without CONV2D_RELU_EN, 0 with it.
   - Stimulus B: center coefficient 32767, others 0, pixels 32767.
   - Response B: 32767 (saturated).
5. Reset mid-frame:
   - Stimulus: reset asserted after pixel 12.
   - Response: next cycle load_kernel_done=0, in_ready=0, valid_out=0; no further outputs. After reload and a full frame, results match scenario 1.
6. Reload rules:
   - Stimulus A: kernel_valid asserted mid-frame.
   - Response A: ignored.
   - Stimulus B: kernel_valid at origin with valid_in=1.
   - Response B: pixel not accepted (in_ready=0); load restarts; bias 5 adds 5 to every scenario-1 output.

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared constants, FSM state type and the shift/saturate helper for conv2d_stream.
package conv2d_pkg;

    localparam int KSIZE      = 3;
    localparam int NUM_TAPS   = 9;
    localparam int LOAD_WORDS = 10;

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    // Arithmetic right shift, then clamp to the signed out_w-bit range.
    function automatic logic signed [63:0] shift_sat(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int out_w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/conv_linebuf.sv
// Two-row line buffer, 3x3 window, raster position counters and window-valid/stride selection.
module conv_linebuf
    import conv2d_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     accept,
    input  logic signed [DATA_W-1:0] pixel,
    input  logic                     stride2,
    output logic                     at_origin,
    output logic signed [DATA_W-1:0] win_p0 [NUM_TAPS],
    output logic                     vld_p0,
    output logic                     last_p0
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX     = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST_S2 = CW'(IMG_W - 1 - ((IMG_W - 3) % 2));
    localparam logic [RW-1:0] ROW_LAST_S2 = RW'(IMG_H - 1 - ((IMG_H - 3) % 2));

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          stride_q;
    logic          stride_eff;
    logic          emit;
    logic          last_pos;

    logic signed [DATA_W-1:0] lb0 [IMG_W];
    logic signed [DATA_W-1:0] lb1 [IMG_W];

    assign at_origin  = (col == '0) && (row == '0);
    // Pixel (0,0) never completes a window, so its own stride bit only matters for later pixels.
    assign stride_eff = at_origin ? stride2 : stride_q;

    always_comb begin
        emit = (row >= RW'(2)) && (col >= CW'(2));
        if (stride_eff) emit = emit && !row[0] && !col[0];
        last_pos = stride_eff ? ((row == ROW_LAST_S2) && (col == COL_LAST_S2))
                              : ((row == ROW_MAX) && (col == COL_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            stride_q <= 1'b0;
            vld_p0   <= 1'b0;
            last_p0  <= 1'b0;
        end else begin
            vld_p0  <= accept && emit;
            last_p0 <= accept && emit && last_pos;
            if (accept) begin
                if (at_origin) stride_q <= stride2;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // P0: window shifts left; rightmost column takes rows r-2, r-1, r at this column.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= pixel;
            lb1[col] <= lb0[col];
            for (int r = 0; r < KSIZE; r++) begin
                win_p0[r*KSIZE]     <= win_p0[r*KSIZE + 1];
                win_p0[r*KSIZE + 1] <= win_p0[r*KSIZE + 2];
            end
            win_p0[KSIZE-1]   <= lb1[col];
            win_p0[2*KSIZE-1] <= lb0[col];
            win_p0[NUM_TAPS-1] <= pixel;
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 3x3 valid-region convolution with loadable kernel/bias, stride 1/2 and saturating output.
// Optional macro CONV2D_RELU_EN clamps negative results to zero after saturation.
module conv2d_stream
    import conv2d_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int ACC_W     = DATA_W + COEF_W + 4,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     kernel_valid,
    input  logic signed [COEF_W-1:0] kernel_in,
    output logic                     load_kernel_done,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     in_ready,
    input  logic                     stride2,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     frame_done
);

    localparam int PROD_W = DATA_W + COEF_W;

    state_t                   state;
    logic [3:0]               widx;
    logic signed [COEF_W-1:0] coef [NUM_TAPS];
    logic signed [COEF_W-1:0] bias;

    logic                     at_origin;
    logic                     accept;
    logic signed [DATA_W-1:0] win_p0 [NUM_TAPS];
    logic                     vld_p0, last_p0;
    logic signed [PROD_W-1:0] prod_p1 [NUM_TAPS];
    logic                     vld_p1, last_p1;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  sum_p2;
    logic                     vld_p2, last_p2;
    logic signed [DATA_W-1:0] result;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
`ifdef CONV2D_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // A kernel word at the origin takes priority over a pixel in the same cycle.
    assign in_ready = load_kernel_done & ~(kernel_valid & at_origin);
    assign accept   = valid_in & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= LOAD;
            widx             <= '0;
            load_kernel_done <= 1'b0;
            bias             <= '0;
            for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (kernel_valid) begin
                        if (widx == 4'(LOAD_WORDS - 1)) begin
                            bias             <= kernel_in;
                            widx             <= '0;
                            load_kernel_done <= 1'b1;
                            state            <= RUN;
                        end else begin
                            coef[widx] <= kernel_in;
                            widx       <= widx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Reload only between frames; the honoured word is word 0.
                    if (kernel_valid && at_origin) begin
                        coef[0]          <= kernel_in;
                        widx             <= 4'd1;
                        load_kernel_done <= 1'b0;
                        state            <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    conv_linebuf #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_linebuf (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .pixel    (data_in),
        .stride2  (stride2),
        .at_origin(at_origin),
        .win_p0   (win_p0),
        .vld_p0   (vld_p0),
        .last_p0  (last_p0)
    );

    // P1: nine full-width products.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TAPS; i++)
            prod_p1[i] <= PROD_W'(win_p0[i]) * PROD_W'(coef[i]);
    end

    always_comb begin
        acc_sum = ACC_W'(bias);
        for (int i = 0; i < NUM_TAPS; i++) acc_sum = acc_sum + ACC_W'(prod_p1[i]);
    end

    // P2: accumulated sum plus bias.
    always_ff @(posedge clk) begin
        sum_p2 <= acc_sum;
    end

    assign result = relu(DATA_W'(shift_sat(64'(sum_p2), OUT_SHIFT, DATA_W)));

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            vld_p2     <= 1'b0;
            last_p2    <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            vld_p1     <= vld_p0;
            last_p1    <= last_p0;
            vld_p2     <= vld_p1;
            last_p2    <= last_p1;
            valid_out  <= vld_p2;
            frame_done <= vld_p2 && last_p2;
            data_out   <= result;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream on a 5x5 image: directed scenarios plus randomized frames.
module tb_conv2d_stream;

    localparam int DW    = 16;
    localparam int KW    = 16;
    localparam int W     = 5;
    localparam int H     = 5;
    localparam int SHIFT = 0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 kernel_valid;
    logic signed [KW-1:0] kernel_in;
    logic                 load_kernel_done;
    logic                 valid_in;
    logic signed [DW-1:0] data_in;
    logic                 in_ready;
    logic                 stride2;
    logic                 valid_out;
    logic signed [DW-1:0] data_out;
    logic                 frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int     kern [10];
    int     pix  [W*H];
    bit     s2;
    longint obs_v [$];
    bit     obs_f [$];
    int     first_cyc;
    int     acc13_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_stream #(
        .DATA_W   (DW),
        .COEF_W   (KW),
        .IMG_W    (W),
        .IMG_H    (H),
        .ACC_W    (DW + KW + 4),
        .OUT_SHIFT(SHIFT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .kernel_valid    (kernel_valid),
        .kernel_in       (kernel_in),
        .load_kernel_done(load_kernel_done),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .in_ready        (in_ready),
        .stride2         (stride2),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .frame_done      (frame_done)
    );

    always @(negedge clk) begin
        if (valid_out) begin
            if (obs_v.size() == 0) first_cyc = cyc;
            obs_v.push_back(longint'(data_out));
            obs_f.push_back(frame_done);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: direct 3x3 dot product over the frame array, then shift, clamp, optional ReLU.
    function automatic longint model_out(input int r, input int c);
        longint acc;
        longint hi;
        longint lo;
        acc = longint'(kern[9]);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc += longint'(kern[i*3+j]) * longint'(pix[(r-2+i)*W + (c-2+j)]);
        acc = acc >>> SHIFT;
        hi  = (longint'(1) <<< (DW-1)) - 1;
        lo  = -(longint'(1) <<< (DW-1));
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
`ifdef CONV2D_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic compare_frame(input string tag);
        longint ev [$];
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                if (!s2 || (((r-2) % 2 == 0) && ((c-2) % 2 == 0)))
                    ev.push_back(model_out(r, c));
        check({tag, "_count"}, obs_v.size(), ev.size());
        for (int i = 0; i < ev.size() && i < obs_v.size(); i++) begin
            check($sformatf("%s_val%0d", tag, i), obs_v[i], ev[i]);
            check($sformatf("%s_fd%0d", tag, i), obs_f[i], (i == ev.size() - 1) ? 1 : 0);
        end
    endtask

    task automatic load_kernel();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            kernel_valid = 1'b1;
            kernel_in    = KW'(kern[i]);
        end
        @(negedge clk);
        kernel_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_max);
        for (int k = lo; k <= hi; k++) begin
            int tries;
            bit acc;
            tries = 0;
            acc   = 1'b0;
            if (gap_max > 0) begin
                repeat ($urandom_range(1, gap_max)) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                end
            end
            while (!acc && tries < 20) begin
                @(negedge clk);
                valid_in = 1'b1;
                data_in  = DW'(pix[k]);
                stride2  = s2;
                #1;
                acc = in_ready;
                @(posedge clk);
                #1;
                tries++;
            end
            if (!acc) begin
                check("accept_timeout", 0, 1);
                @(negedge clk);
                valid_in = 1'b0;
                return;
            end
            if (k == 12) acc13_cyc = cyc;
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap_max);
        obs_v.delete();
        obs_f.delete();
        first_cyc = -1;
        send_range(0, W*H - 1, gap_max);
        repeat (8) @(negedge clk);
        compare_frame(tag);
    endtask

    task automatic set_ones_ramp(input int b);
        for (int i = 0; i < 9; i++) kern[i] = 1;
        kern[9] = b;
        for (int p = 0; p < W*H; p++) pix[p] = p + 1;
    endtask

    initial begin
        reset        = 1'b1;
        kernel_valid = 1'b0;
        kernel_in    = '0;
        valid_in     = 1'b0;
        data_in      = '0;
        stride2      = 1'b0;
        s2           = 1'b0;
        first_cyc    = -1;
        acc13_cyc    = 0;
        repeat (2) @(negedge clk);
        check("rst_lkd", load_kernel_done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_vout", valid_out, 0);
        check("rst_dout", data_out, 0);
        check("rst_fd", frame_done, 0);
        reset = 1'b0;

        // Basic stride 1 with latency check
        set_ones_ramp(0);
        load_kernel();
        check("s1_lkd", load_kernel_done, 1);
        run_frame("s1", 0);
        check("s1_latency", first_cyc - acc13_cyc, 3);
        check("s1_first", (obs_v.size() > 0) ? obs_v[0] : -1, 63);

        // Stride 2
        s2 = 1'b1;
        run_frame("s2", 0);
        s2 = 1'b0;

        // Gapped input
        run_frame("s3", 1);

        // Sign and ReLU
        for (int i = 0; i < 9; i++) kern[i] = -1;
        kern[9] = 0;
        for (int p = 0; p < W*H; p++) pix[p] = 1000;
        load_kernel();
        run_frame("s4a", 0);
`ifdef CONV2D_RELU_EN
        check("s4a_const", (obs_v.size() > 0) ? obs_v[0] : -1, 0);
`else
        check("s4a_const", (obs_v.size() > 0) ? obs_v[0] : -1, -9000);
`endif

        // Positive saturation
        for (int i = 0; i < 10; i++) kern[i] = 0;
        kern[4] = 32767;
        for (int p = 0; p < W*H; p++) pix[p] = 32767;
        load_kernel();
        run_frame("s4b", 0);
        check("s4b_const", (obs_v.size() > 0) ? obs_v[0] : -1, 32767);

        // Reset mid-frame
        set_ones_ramp(0);
        load_kernel();
        obs_v.delete();
        obs_f.delete();
        send_range(0, 11, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("s5_lkd", load_kernel_done, 0);
        check("s5_ready", in_ready, 0);
        check("s5_vout", valid_out, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("s5_no_out", obs_v.size(), 0);
        load_kernel();
        run_frame("s5", 0);

        // Mid-frame kernel word is ignored
        obs_v.delete();
        obs_f.delete();
        send_range(0, 6, 0);
        @(negedge clk);
        kernel_valid = 1'b1;
        kernel_in    = 16'sd99;
        @(negedge clk);
        kernel_valid = 1'b0;
        check("s6a_lkd", load_kernel_done, 1);
        send_range(7, W*H - 1, 0);
        repeat (8) @(negedge clk);
        compare_frame("s6a");

        // Kernel word at origin wins over a pixel; reload with bias 5
        set_ones_ramp(5);
        @(negedge clk);
        kernel_valid = 1'b1;
        kernel_in    = KW'(kern[0]);
        valid_in     = 1'b1;
        data_in      = 16'sd77;
        #1;
        check("s6b_ready", in_ready, 0);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) check("s6b_lkd_clr", load_kernel_done, 0);
            valid_in     = 1'b0;
            kernel_valid = 1'b1;
            kernel_in    = KW'(kern[i]);
        end
        @(negedge clk);
        kernel_valid = 1'b0;
        check("s6b_lkd", load_kernel_done, 1);
        run_frame("s6b", 0);
        check("s6b_first", (obs_v.size() > 0) ? obs_v[0] : -1, 68);

        // Randomized frames
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 10; i++)
                kern[i] = (t % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 40)) - 20;
            for (int p = 0; p < W*H; p++)
                pix[p] = (t % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                      : int'($urandom_range(0, 200)) - 100;
            s2 = $urandom_range(0, 1) != 0;
            load_kernel();
            check($sformatf("rnd%0d_lkd", t), load_kernel_done, 1);
            run_frame($sformatf("rnd%0d", t), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
